// File: rtl/data_mem_sequencer.sv
// Load/store sequencer between the core and a word-wide request/acknowledge data bus.
// Optional MISALIGN_CHECK_EN aborts misaligned halfword/word accesses without a bus cycle.
module data_mem_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic             i_one_byte,
    input  logic             i_two_bytes,
    input  logic             i_four_bytes,
    input  logic             i_load_unsigned,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_stall,
    output logic             o_err,
    output logic             o_bus_req,
    output logic             o_bus_we,
    output logic [WIDTH-1:0] o_bus_addr,
    output logic [3:0]       o_bus_be,
    output logic [WIDTH-1:0] o_bus_wdata,
    input  logic [WIDTH-1:0] i_bus_rdata,
    input  logic             i_bus_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t           r_state;
    size_t            r_size;
    logic [1:0]       r_off;
    logic             r_unsigned;
    logic             r_is_read;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rdata;
    logic             r_err;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [WIDTH-1:0] r_bus_addr;
    logic [3:0]       r_bus_be;
    logic [WIDTH-1:0] r_bus_wdata;

    logic             w_req;
    size_t            w_size;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic             w_misaligned;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;

    assign w_req = i_mem_read | i_mem_write;

    // A word is the fallback when no size flag is set.
    always_comb begin
        w_size  = SZ_WORD;
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (i_four_bytes) begin
            w_size = SZ_WORD;
        end else if (i_one_byte) begin
            w_size = SZ_BYTE;
        end else if (i_two_bytes) begin
            w_size = SZ_HALF;
        end
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = WIDTH'({4{i_wdata[7:0]}});
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = WIDTH'({2{i_wdata[15:0]}});
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    assign w_misaligned = ((w_size == SZ_HALF) && i_addr[0]) ||
                          ((w_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Lane extraction uses the offset captured in IDLE, not the live address.
    always_comb begin
        w_byte = i_bus_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = i_bus_rdata[15:8];
            2'd2:    w_byte = i_bus_rdata[23:16];
            2'd3:    w_byte = i_bus_rdata[31:24];
            default: w_byte = i_bus_rdata[7:0];
        endcase
        w_half = r_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (r_size)
            SZ_BYTE: w_load = r_unsigned ? WIDTH'(w_byte)
                                         : {{(WIDTH-8){w_byte[7]}}, w_byte};
            SZ_HALF: w_load = r_unsigned ? WIDTH'(w_half)
                                         : {{(WIDTH-16){w_half[15]}}, w_half};
            default: w_load = i_bus_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_size      <= SZ_WORD;
            r_off       <= 2'b00;
            r_unsigned  <= 1'b0;
            r_is_read   <= 1'b0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_err <= 1'b0;
                    if (w_req) begin
                        if (w_misaligned) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state     <= ACCESS;
                            r_size      <= w_size;
                            r_off       <= i_addr[1:0];
                            r_unsigned  <= i_load_unsigned;
                            r_is_read   <= i_mem_read;
                            r_cnt       <= '0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= ~i_mem_read;
                            r_bus_addr  <= {i_addr[WIDTH-1:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (i_bus_ack) begin
                        r_state   <= DONE;
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                        if (r_is_read) begin
                            r_rdata <= w_load;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= ERR;
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_stall     = ~i_rst & ((w_req & (r_state == IDLE)) | (r_state == ACCESS));
    assign o_rdata     = r_rdata;
    assign o_err       = r_err;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_be    = r_bus_be;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Scoreboard bench for data_mem_sequencer: stimulus queues expected results, a
// negedge monitor pops them when a transaction ends (stall falls).
module tb_data_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic        oneByte = 1'b0, twoBytes = 1'b0, fourBytes = 1'b0;
    logic        loadUnsigned = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        stall, err, busReq, busWe;
    logic [31:0] busAddr, busWdata;
    logic [3:0]  busBe;
    logic [31:0] busRdata = '0;
    logic        busAck = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          err;
        bit          checkRdata;
        logic [31:0] rdata;
        int          stalls;
        bit          expReq;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          checkWdata;
        logic [31:0] wdata;
    } exp_t;

    exp_t expQ[$];

    int ackDelay  = -1;
    bit manualAck = 1'b0;
    int waitCnt   = 0;

    data_mem_sequencer #(.WIDTH(32), .TIMEOUT(15)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mem_read     (memRead),
        .i_mem_write    (memWrite),
        .i_one_byte     (oneByte),
        .i_two_bytes    (twoBytes),
        .i_four_bytes   (fourBytes),
        .i_load_unsigned(loadUnsigned),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_rdata        (rdata),
        .o_stall        (stall),
        .o_err          (err),
        .o_bus_req      (busReq),
        .o_bus_we       (busWe),
        .o_bus_addr     (busAddr),
        .o_bus_be       (busBe),
        .o_bus_wdata    (busWdata),
        .i_bus_rdata    (busRdata),
        .i_bus_ack      (busAck)
    );

    always #5 clk = ~clk;

    // Memory model: acks after ackDelay request cycles; ackDelay < 0 never acks.
    always @(posedge clk) begin
        #2;
        if (manualAck) begin
            busAck = 1'b1;
        end else if (busReq) begin
            if (ackDelay >= 0 && waitCnt == ackDelay) begin
                busAck = 1'b1;
            end else begin
                busAck = 1'b0;
                waitCnt++;
            end
        end else begin
            busAck  = 1'b0;
            waitCnt = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input string name, input bit e, input bit cr,
                                   input logic [31:0] r, input int s, input bit q,
                                   input bit we, input logic [31:0] a, input logic [3:0] be,
                                   input bit cw, input logic [31:0] wd);
        exp_t x;
        x.name = name; x.err = e; x.checkRdata = cr; x.rdata = r; x.stalls = s;
        x.expReq = q; x.we = we; x.addr = a; x.be = be; x.checkWdata = cw; x.wdata = wd;
        return x;
    endfunction

    int          stallCnt  = 0;
    bit          prevStall = 1'b0;
    bit          sawReq    = 1'b0;
    logic        snapWe;
    logic [31:0] snapAddr, snapWdata;
    logic [3:0]  snapBe;

    // Monitor: a falling stall marks DONE or ERR, where the result is compared.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stallCnt  = 0;
            prevStall = 1'b0;
            sawReq    = 1'b0;
        end else begin
            if (stall) begin
                stallCnt++;
                if (busReq) begin
                    sawReq    = 1'b1;
                    snapWe    = busWe;
                    snapAddr  = busAddr;
                    snapBe    = busBe;
                    snapWdata = busWdata;
                end
            end else if (prevStall) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResult actual=err%0b/%h required=no transaction", err, rdata);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, ".err"}, 32'(err), 32'(e.err));
                    if (e.checkRdata) checkOutput({e.name, ".rdata"}, rdata, e.rdata);
                    checkOutput({e.name, ".stalls"}, 32'(stallCnt), 32'(e.stalls));
                    checkOutput({e.name, ".sawReq"}, 32'(sawReq), 32'(e.expReq));
                    checkOutput({e.name, ".busReqAtEnd"}, 32'(busReq), 32'd0);
                    if (e.expReq && sawReq) begin
                        checkOutput({e.name, ".busWe"}, 32'(snapWe), 32'(e.we));
                        checkOutput({e.name, ".busAddr"}, snapAddr, e.addr);
                        checkOutput({e.name, ".busBe"}, 32'(snapBe), 32'(e.be));
                        if (e.checkWdata) checkOutput({e.name, ".busWdata"}, snapWdata, e.wdata);
                    end
                end
                stallCnt = 0;
                sawReq   = 1'b0;
            end
            prevStall = stall;
        end
    end

    // size is {one_byte, two_bytes, four_bytes}; called at posedge+1.
    task automatic applyStimulus(input exp_t e, input bit rd, input bit wr, input logic [2:0] size,
                                 input bit uns, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdv, input int delay);
        int n = 0;
        expQ.push_back(e);
        busRdata     = rdv;
        ackDelay     = delay;
        memRead      = rd;
        memWrite     = wr;
        {oneByte, twoBytes, fourBytes} = size;
        loadUnsigned = uns;
        addr         = a;
        wdata        = wd;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (stall && n < 40);
        if (stall) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.completion actual=still stalled required=done within 40 cycles", e.name);
        end
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busReq", 32'(busReq), 32'd0);
        checkOutput("reset.busWe", 32'(busWe), 32'd0);
        checkOutput("reset.busAddr", busAddr, 32'd0);
        checkOutput("reset.busBe", 32'(busBe), 32'd0);
        checkOutput("reset.busWdata", busWdata, 32'd0);
        checkOutput("reset.rdata", rdata, 32'd0);
        checkOutput("reset.err", 32'(err), 32'd0);
        checkOutput("reset.stall", 32'(stall), 32'd0);
        rst = 1'b0;

        applyStimulus(mkExp("byteLoadSigned", 0, 1, 32'hFFFF_FF80, 2, 1, 0, 32'h100, 4'b1000, 1, 32'h4444_4444),
                      1, 0, 3'b100, 0, 32'h103, 32'h1122_3344, 32'h80FF_1234, 0);
        applyStimulus(mkExp("halfStore", 0, 1, 32'hFFFF_FF80, 4, 1, 1, 32'h200, 4'b1100, 1, 32'hBEEF_BEEF),
                      0, 1, 3'b010, 0, 32'h202, 32'hDEAD_BEEF, 32'h0, 2);
        applyStimulus(mkExp("halfLoadUnsigned", 0, 1, 32'h0000_8001, 3, 1, 0, 32'h0, 4'b0011, 1, 32'h0),
                      1, 0, 3'b010, 1, 32'h0, 32'h0, 32'h1234_8001, 1);
        applyStimulus(mkExp("halfLoadSignedHi", 0, 1, 32'hFFFF_8001, 2, 1, 0, 32'h0, 4'b1100, 0, 32'h0),
                      1, 0, 3'b010, 0, 32'h2, 32'h0, 32'h8001_7FFF, 0);
        applyStimulus(mkExp("byteLoadUnsigned", 0, 1, 32'h0000_00AB, 2, 1, 0, 32'h100, 4'b0010, 0, 32'h0),
                      1, 0, 3'b100, 1, 32'h101, 32'h0, 32'h0000_AB00, 0);
        applyStimulus(mkExp("wordLoadTimeout", 1, 1, 32'h0, 16, 1, 0, 32'h300, 4'b1111, 0, 32'h0),
                      1, 0, 3'b001, 0, 32'h300, 32'h0, 32'h5555_5555, -1);
`ifdef MISALIGN_CHECK_EN
        applyStimulus(mkExp("wordStoreMisaligned", 1, 1, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 0, 32'h0),
                      0, 1, 3'b001, 0, 32'h101, 32'hCAFE_F00D, 32'h0, 0);
`else
        applyStimulus(mkExp("wordStoreMasked", 0, 1, 32'h0, 2, 1, 1, 32'h100, 4'b1111, 1, 32'hCAFE_F00D),
                      0, 1, 3'b001, 0, 32'h101, 32'hCAFE_F00D, 32'h0, 0);
`endif
        applyStimulus(mkExp("readWinsNoSize", 0, 1, 32'h89AB_CDEF, 2, 1, 0, 32'h10, 4'b1111, 0, 32'h0),
                      1, 1, 3'b000, 0, 32'h10, 32'h0, 32'h89AB_CDEF, 0);
        applyStimulus(mkExp("byteStore", 0, 1, 32'h89AB_CDEF, 2, 1, 1, 32'h0, 4'b0100, 1, 32'hA5A5_A5A5),
                      0, 1, 3'b100, 0, 32'h2, 32'h0000_00A5, 32'h0, 0);
`ifdef MISALIGN_CHECK_EN
        applyStimulus(mkExp("halfLoadMisaligned", 1, 1, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 0, 32'h0),
                      1, 0, 3'b010, 0, 32'h203, 32'h0, 32'h7FFE_0000, 0);
`else
        applyStimulus(mkExp("halfLoadMasked", 0, 1, 32'h0000_7FFE, 2, 1, 0, 32'h200, 4'b1100, 0, 32'h0),
                      1, 0, 3'b010, 0, 32'h203, 32'h0, 32'h7FFE_0000, 0);
`endif

        // Reset in the second ACCESS cycle, then a stray ack one cycle later.
        ackDelay  = -1;
        busRdata  = 32'h1357_9BDF;
        memRead   = 1'b1;
        fourBytes = 1'b1;
        oneByte   = 1'b0;
        twoBytes  = 1'b0;
        addr      = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midReset.stallForcedLow", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        memRead   = 1'b0;
        manualAck = 1'b1;
        checkOutput("midReset.busReq", 32'(busReq), 32'd0);
        checkOutput("midReset.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        manualAck = 1'b0;
        checkOutput("lateAck.busReq", 32'(busReq), 32'd0);
        checkOutput("lateAck.stall", 32'(stall), 32'd0);
        checkOutput("lateAck.err", 32'(err), 32'd0);
        checkOutput("lateAck.rdata", rdata, 32'd0);
        @(posedge clk); #1;

        applyStimulus(mkExp("afterReset", 0, 1, 32'h0000_007F, 2, 1, 0, 32'h0, 4'b0001, 0, 32'h0),
                      1, 0, 3'b100, 0, 32'h0, 32'h0, 32'h0000_007F, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
